aw_w_b_channel: RTL

Write-side companion to the read channel inside the SRAM-to-AXI bridge. Accepts write requests from the data SRAM-like interface, issues one single-beat AXI write (AW and W handshakes independent), then waits for the B response and returns data_ok. It also exports busy/address status so the read channel can block reads that hit an in-flight write.

---
 rtl/bridge_pkg.sv | 44 ++++
 rtl/wr_payload_reg.sv | 54 +++++
 rtl/aw_w_b_channel.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Shared definitions for the SRAM-to-AXI bridge channels:
//               channel state encoding, fixed AXI attribute values, channel
//               ID assignments and the SRAM-side transfer size encoding.
//               Imported by both the read and the write channel.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

  // Channel state encoding shared by the read and write channels.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_WAIT_B = 2'd2
  } chan_state_e;

  // Fixed AXI attributes: single-beat INCR, normal access, no lock.
  localparam logic [1:0] C_AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] C_AXI_LEN_SINGLE = 8'd0;
  localparam logic [3:0] C_AXI_CACHE_NONE = 4'd0;
  localparam logic [2:0] C_AXI_PROT_NONE  = 3'd0;
  localparam logic [1:0] C_AXI_LOCK_NONE  = 2'd0;
  localparam logic [1:0] C_AXI_RESP_OKAY  = 2'b00;

  // Transaction IDs per requester.
  localparam logic [3:0] C_ID_INST_RD = 4'd0;
  localparam logic [3:0] C_ID_DATA_RD = 4'd1;
  localparam logic [3:0] C_ID_DATA_WR = 4'd1;

  // SRAM-side size encoding (matches AXI AxSIZE low bits).
  localparam logic [1:0] C_SIZE_BYTE = 2'd0;
  localparam logic [1:0] C_SIZE_HALF = 2'd1;
  localparam logic [1:0] C_SIZE_WORD = 2'd2;

  // SRAM size to AXI AxSIZE: transfers never exceed one word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wr_payload_reg.sv
`default_nettype none
// ============================================================================
// Module      : wr_payload_reg
// Description : Captures the address, size, byte strobes and data of an
//               accepted write request and holds them until the next accept,
//               so the AXI AW/W payload stays stable while valid is high.
// Ports       : clk, resetn (async active-low)
//               i_load              - capture enable (request accepted)
//               i_addr/i_size/i_wstrb/i_wdata - incoming request payload
//               o_addr/o_size/o_wstrb/o_wdata - held payload
// Revision    : 1.0 - initial release
// ============================================================================
module wr_payload_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  input  logic [3:0]        i_wstrb,
  input  logic [31:0]       i_wdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_size,
  output logic [3:0]        o_wstrb,
  output logic [31:0]       o_wdata
);

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_size  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_size  <= i_size;
      r_wstrb <= i_wstrb;
      r_wdata <= i_wdata;
    end
  end

  assign o_addr  = r_addr;
  assign o_size  = r_size;
  assign o_wstrb = r_wstrb;
  assign o_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/aw_w_b_channel.sv
`default_nettype none
// ============================================================================
// Module      : aw_w_b_channel
// Description : Write channel of the SRAM-to-AXI bridge. Accepts one write
//               from the data SRAM-like port, issues a single-beat AXI write
//               (AW and W handshakes independent), waits for B and returns
//               data_ok. Exports busy/address status for read-hazard checks.
//               Optional macro AXI_WR_RESP_CHK_EN adds sticky wr_err and
//               wr_err_addr reporting of non-OKAY write responses.
// Ports       : clk, resetn (async active-low)
//               data_sram_*       - SRAM-like write request / response
//               aw*, w*, b*       - AXI write address, data, response
//               wr_busy, wr_addr  - in-flight status for the read channel
//               wr_err, wr_err_addr (AXI_WR_RESP_CHK_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module aw_w_b_channel
  import bridge_pkg::*;
#(
  parameter logic [3:0] WR_ID  = C_ID_DATA_WR,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // SRAM-like request side
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  // AXI AW
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // AXI W
  output logic [3:0]        wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI B
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
`ifdef AXI_WR_RESP_CHK_EN
  output logic              wr_err,
  output logic [ADDR_W-1:0] wr_err_addr,
`endif
  // Status for the read channel
  output logic              wr_busy,
  output logic [ADDR_W-1:0] wr_addr
);

  chan_state_e r_state;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_aw_done;
  logic        r_w_done;

  logic              w_b_fire;
  logic              w_accept;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_done;
  logic              w_w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_size;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;

  // Responses carrying another master's ID are left for their owner.
  assign w_b_fire = bvalid & r_bready & (bid == WR_ID);

  // A new write may be taken while idle, or in the very cycle the current
  // response is consumed (back-to-back). Held off while reset is asserted.
  assign w_accept = resetn & data_sram_req & data_sram_wr &
                    ((r_state == ST_IDLE) | ((r_state == ST_WAIT_B) & w_b_fire));

  assign w_aw_hs   = r_awvalid & awready;
  assign w_w_hs    = r_wvalid & wready;
  assign w_aw_done = r_aw_done | w_aw_hs;
  assign w_w_done  = r_w_done | w_w_hs;

  wr_payload_reg #(
    .ADDR_W (ADDR_W)
  ) u_payload (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_accept),
    .i_addr  (data_sram_addr),
    .i_size  (data_sram_size),
    .i_wstrb (data_sram_wstrb),
    .i_wdata (data_sram_wdata),
    .o_addr  (w_addr),
    .o_size  (w_size),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_SEND;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Covers both handshakes landing together or in either order.
          if (w_aw_done && w_w_done) begin
            r_state  <= ST_WAIT_B;
            r_bready <= 1'b1;
          end
        end
        ST_WAIT_B: begin
          if (w_b_fire) begin
            r_bready <= 1'b0;
            if (w_accept) begin
              r_state   <= ST_SEND;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
        end
      endcase
    end
  end

  assign data_sram_addr_ok = w_accept;
  assign data_sram_data_ok = w_b_fire;

  assign awid    = WR_ID;
  assign awaddr  = w_addr;
  assign awlen   = C_AXI_LEN_SINGLE;
  assign awsize  = axi_size(w_size);
  assign awburst = C_AXI_BURST_INCR;
  assign awlock  = C_AXI_LOCK_NONE;
  assign awcache = C_AXI_CACHE_NONE;
  assign awprot  = C_AXI_PROT_NONE;
  assign awvalid = r_awvalid;

  assign wid    = WR_ID;
  assign wdata  = w_wdata;
  assign wstrb  = w_wstrb;
  assign wlast  = 1'b1;
  assign wvalid = r_wvalid;

  assign bready = r_bready;

  assign wr_busy = (r_state != ST_IDLE);
  assign wr_addr = w_addr;

`ifdef AXI_WR_RESP_CHK_EN
  logic              r_wr_err;
  logic [ADDR_W-1:0] r_wr_err_addr;

  // Sticky: only the first failing write's address is kept. w_addr still
  // holds the completing write here even if a back-to-back accept loads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_err      <= 1'b0;
      r_wr_err_addr <= '0;
    end else if (w_b_fire && (bresp != C_AXI_RESP_OKAY) && !r_wr_err) begin
      r_wr_err      <= 1'b1;
      r_wr_err_addr <= w_addr;
    end
  end

  assign wr_err      = r_wr_err;
  assign wr_err_addr = r_wr_err_addr;
`else
  logic w_unused_bresp;
  assign w_unused_bresp = ^bresp;
`endif

endmodule
`default_nettype wire
